// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and instruction-BRAM write port of the program loader
interface prog_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [9:0]  mem_addr;
    logic [17:0] mem_wdata;
    logic [3:0]  mem_we;
    modport slave (input rx_data, rx_valid, output rx_ready, mem_addr, mem_wdata, mem_we);
    modport master (output rx_data, rx_valid, input rx_ready, mem_addr, mem_wdata, mem_we);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: parses a framed byte stream into 18-bit PicoBlaze instruction writes, holding the core in reset while loading
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {IDLE, AH, AL, CH, CL, W0, W1, W2, WR, CHK} state_t;

    state_t        state, state_nxt;
    logic [7:0]    sum, sum_nxt, b1, b2;
    logic [1:0]    b0, cnt_hi;
    logic [9:0]    addr, rem;
    logic [TW-1:0] timer;
    logic          accept, timeout, hdr_bad, chk_end, chk_ok;

    assign accept        = bus.rx_valid && bus.rx_ready;
    assign sum_nxt       = sum + bus.rx_data;
    assign timeout       = state != IDLE && !accept && timer == T_LAST;
    assign hdr_bad       = accept && (state == AH || state == CH) && |bus.rx_data[7:2];
    assign chk_end       = accept && state == CHK;
    assign chk_ok        = sum_nxt == 8'd0;
    assign bus.rx_ready  = state != WR;
    assign bus.mem_we    = state == WR ? 4'hF : 4'h0;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = {b0, b1, b2};
    assign busy          = state != IDLE;

    // state register; async reset drops any pending write immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: aborts win, WR advances unconditionally, other states step on an accepted byte
    always_comb begin
        state_nxt = state;
        if (timeout || hdr_bad)
            state_nxt = IDLE;
        else if (state == WR)
            state_nxt = rem == 10'd0 ? CHK : W0;
        else if (accept)
            case (state)
                IDLE:    state_nxt = bus.rx_data == SYNC_BYTE ? AH : IDLE;
                AH:      state_nxt = AL;
                AL:      state_nxt = CH;
                CH:      state_nxt = CL;
                CL:      state_nxt = W0;
                W0:      state_nxt = W1;
                W1:      state_nxt = W2;
                W2:      state_nxt = WR;
                default: state_nxt = IDLE;
            endcase
    end

    // datapath: header/word latches, checksum, idle timer, status pulses and core reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            timer     <= '0;
            addr      <= '0;
            rem       <= '0;
            cnt_hi    <= '0;
            b0        <= '0;
            b1        <= '0;
            b2        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
            cpu_reset <= 1'b0;
        end else begin
            done     <= chk_end && chk_ok;
            err      <= timeout || hdr_bad || (chk_end && !chk_ok);
            err_code <= timeout ? 2'b10 : hdr_bad ? 2'b11 : (chk_end && !chk_ok) ? 2'b01 : err_code;
            timer    <= (state == IDLE || accept || timeout) ? '0 : timer + 1'b1;
            if (accept)
                sum <= state == IDLE ? 8'd0 : sum_nxt;
            if (state == IDLE && accept && bus.rx_data == SYNC_BYTE)
                cpu_reset <= 1'b1;
            else if (chk_end && chk_ok)
                cpu_reset <= 1'b0;
            if (state == WR) begin
                addr <= addr + 10'd1;
                rem  <= rem - 10'd1;
            end else if (accept)
                case (state)
                    AH:      addr[9:8] <= bus.rx_data[1:0];
                    AL:      addr[7:0] <= bus.rx_data;
                    CH:      cnt_hi    <= bus.rx_data[1:0];
                    CL:      rem       <= {cnt_hi, bus.rx_data};
                    W0:      b0        <= bus.rx_data[1:0];
                    W1:      b1        <= bus.rx_data;
                    W2:      b2        <= bus.rx_data;
                    default: ;
                endcase
        end
    end
endmodule
